// File: rtl/mc_pkg.sv
// Shared definitions for the mc_ctrl_seq multi-cycle control sequencer.
// Holds the FSM state encoding, the instruction classes produced by the
// decoder, MIPS opcode/funct constants and the datapath select encodings.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EXE  = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      IC_R    = 4'd0,   // R-type ALU op, writes rd
      IC_IMM  = 4'd1,   // I-type ALU op (ori/addiu/lui), writes rt
      IC_LW   = 4'd2,
      IC_SW   = 4'd3,
      IC_BEQ  = 4'd4,
      IC_J    = 4'd5,
      IC_JAL  = 4'd6,
      IC_HALT = 4'd7,
      IC_ILL  = 4'd8
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2a;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_LUI = 3'b101;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_JMP = 2'b10;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_DM  = 2'b01;
   localparam logic [1:0] M2R_PC4 = 2'b10;
   localparam logic [1:0] M2R_EXT = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for mc_ctrl_seq.
// Ports: op/funct (IR fields) in; iclass (instruction class), alu_ctr,
// ext_op, alusrc and illegal (unsupported op/funct) out.
module mc_decode
   import mc_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'h3f
) (
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output logic [2:0] alu_ctr,
   output logic [1:0] ext_op,
   output logic       alusrc,
   output logic       illegal
);

   // Map op/funct to class and EXE-stage ALU controls.
   always_comb begin
      iclass  = IC_ILL;
      alu_ctr = ALU_ADD;
      ext_op  = EXT_ZERO;
      alusrc  = 1'b0;
      // HALT_OP is a parameter, so it is checked ahead of the fixed opcodes.
      if (op == HALT_OP) begin
         iclass = IC_HALT;
      end else begin
         case (op)
            OP_RTYPE: begin
               case (funct)
                  FN_ADD:  begin iclass = IC_R; alu_ctr = ALU_ADD; end
                  FN_SUB:  begin iclass = IC_R; alu_ctr = ALU_SUB; end
                  FN_AND:  begin iclass = IC_R; alu_ctr = ALU_AND; end
                  FN_OR:   begin iclass = IC_R; alu_ctr = ALU_OR;  end
                  FN_SLT:  begin iclass = IC_R; alu_ctr = ALU_SLT; end
                  default: iclass = IC_ILL;
               endcase
            end
            OP_ORI:   begin iclass = IC_IMM; alu_ctr = ALU_OR;  ext_op = EXT_ZERO; alusrc = 1'b1; end
            OP_ADDIU: begin iclass = IC_IMM; alu_ctr = ALU_ADD; ext_op = EXT_SIGN; alusrc = 1'b1; end
            OP_LUI:   begin iclass = IC_IMM; alu_ctr = ALU_LUI; ext_op = EXT_LUI;  alusrc = 1'b1; end
            OP_LW:    begin iclass = IC_LW;  alu_ctr = ALU_ADD; ext_op = EXT_SIGN; alusrc = 1'b1; end
            OP_SW:    begin iclass = IC_SW;  alu_ctr = ALU_ADD; ext_op = EXT_SIGN; alusrc = 1'b1; end
            OP_BEQ:   begin iclass = IC_BEQ; alu_ctr = ALU_SUB; ext_op = EXT_SIGN; alusrc = 1'b0; end
            OP_J:     iclass = IC_J;
            OP_JAL:   iclass = IC_JAL;
            default:  iclass = IC_ILL;
         endcase
      end
   end

   assign illegal = (iclass == IC_ILL);

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer for the MIPS subset core.
// Ports: clk, rst (sync active-high); op/funct from IR, ALU zero flag,
// imem_ack/dmem_ack handshakes in. Out: memory requests, PC/IR/RF/DM
// write enables, datapath selects, debug state, halted, sticky err and
// the retired-instruction counter.
// Control outputs are decoded from the state register and forced to zero
// while rst is high, so a reset cycle never issues a write.
module mc_ctrl_seq
   import mc_pkg::*;
#(
   parameter int         TIMEOUT = 16,
   parameter int         CNT_W   = 5,
   parameter int         PERF_W  = 32,
   parameter logic [5:0] HALT_OP = 6'h3f
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic              zero,
   input  logic              imem_ack,
   input  logic              dmem_ack,
   output logic              imem_req,
   output logic              dmem_req,
   output logic              pc_we,
   output logic              ir_we,
   output logic              rf_we,
   output logic              dm_we,
   output logic [2:0]        alu_ctr,
   output logic [1:0]        ext_op,
   output logic [1:0]        npc_sel,
   output logic [1:0]        regdst_sel,
   output logic [1:0]        memtoreg_sel,
   output logic              alusrc_sel,
   output logic [2:0]        state,
   output logic              halted,
   output logic              err,
   output logic [PERF_W-1:0] retired
);

   localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

   state_t            state_r, state_nxt;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt;
   logic [CNT_W:0]    cnt_inc_s;
   logic              to_s;
   logic              err_r, err_nxt;
   logic              retire_s;
   logic [PERF_W-1:0] retired_r;

   iclass_t           iclass_s;
   logic [2:0]        dec_alu_s;
   logic [1:0]        dec_ext_s;
   logic              dec_asrc_s;
   logic              illegal_s;

   mc_decode #(.HALT_OP(HALT_OP)) u_decode (
      .op      (op),
      .funct   (funct),
      .iclass  (iclass_s),
      .alu_ctr (dec_alu_s),
      .ext_op  (dec_ext_s),
      .alusrc  (dec_asrc_s),
      .illegal (illegal_s)
   );

   // One extra bit so the TIMEOUT compare cannot wrap.
   assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
   // The waiting cycle whose count reaches TIMEOUT is the last one allowed.
   assign to_s      = (cnt_inc_s >= TO_LIM);

   // State, counter, sticky error and retired counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IF;
         cnt_r     <= {CNT_W{1'b0}};
         err_r     <= 1'b0;
         retired_r <= {PERF_W{1'b0}};
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         err_r   <= err_nxt;
         if (retire_s) begin
            retired_r <= retired_r + {{(PERF_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Next-state and control-output decode.
   always_comb begin
      state_nxt    = state_r;
      cnt_nxt      = cnt_r;
      err_nxt      = err_r;
      retire_s     = 1'b0;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      pc_we        = 1'b0;
      ir_we        = 1'b0;
      rf_we        = 1'b0;
      dm_we        = 1'b0;
      alu_ctr      = ALU_ADD;
      ext_op       = EXT_ZERO;
      npc_sel      = NPC_SEQ;
      regdst_sel   = RDST_RT;
      memtoreg_sel = M2R_ALU;
      alusrc_sel   = 1'b0;
      halted       = 1'b0;
      if (rst) begin
         // Outputs stay at their zero defaults for the whole reset cycle.
         state_nxt = ST_IF;
         cnt_nxt   = {CNT_W{1'b0}};
         err_nxt   = 1'b0;
      end else begin
         case (state_r)
            ST_IF: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we     = 1'b1;
                  pc_we     = 1'b1;
                  npc_sel   = NPC_SEQ;
                  cnt_nxt   = {CNT_W{1'b0}};
                  state_nxt = ST_ID;
               end else if (to_s) begin
                  err_nxt   = 1'b1;
                  cnt_nxt   = {CNT_W{1'b0}};
                  state_nxt = ST_HALT;
               end else begin
                  cnt_nxt   = cnt_inc_s[CNT_W-1:0];
               end
            end
            ST_ID: begin
               if (illegal_s) begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_HALT;
               end else begin
                  case (iclass_s)
                     IC_J: begin
                        pc_we     = 1'b1;
                        npc_sel   = NPC_JMP;
                        retire_s  = 1'b1;
                        state_nxt = ST_IF;
                     end
                     IC_JAL:  state_nxt = ST_WB;
                     IC_HALT: begin
                        retire_s  = 1'b1;
                        state_nxt = ST_HALT;
                     end
                     default: state_nxt = ST_EXE;
                  endcase
               end
            end
            ST_EXE: begin
               alu_ctr    = dec_alu_s;
               ext_op     = dec_ext_s;
               alusrc_sel = dec_asrc_s;
               case (iclass_s)
                  IC_BEQ: begin
                     pc_we     = zero;
                     npc_sel   = NPC_BR;
                     retire_s  = 1'b1;
                     state_nxt = ST_IF;
                  end
                  IC_LW, IC_SW: state_nxt = ST_MEM;
                  IC_R, IC_IMM: state_nxt = ST_WB;
                  default: begin
                     // IR changed under us: treat as illegal.
                     err_nxt   = 1'b1;
                     state_nxt = ST_HALT;
                  end
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               if (dmem_ack) begin
                  cnt_nxt = {CNT_W{1'b0}};
                  if (iclass_s == IC_SW) begin
                     dm_we     = 1'b1;
                     retire_s  = 1'b1;
                     state_nxt = ST_IF;
                  end else begin
                     state_nxt = ST_WB;
                  end
               end else if (to_s) begin
                  err_nxt   = 1'b1;
                  cnt_nxt   = {CNT_W{1'b0}};
                  state_nxt = ST_HALT;
               end else begin
                  cnt_nxt   = cnt_inc_s[CNT_W-1:0];
               end
            end
            ST_WB: begin
               rf_we     = 1'b1;
               retire_s  = 1'b1;
               state_nxt = ST_IF;
               case (iclass_s)
                  IC_R:   regdst_sel   = RDST_RD;
                  IC_LW:  memtoreg_sel = M2R_DM;
                  IC_JAL: begin
                     regdst_sel   = RDST_RA;
                     memtoreg_sel = M2R_PC4;
                     pc_we        = 1'b1;
                     npc_sel      = NPC_JMP;
                  end
                  default: begin
                     regdst_sel   = RDST_RT;
                     memtoreg_sel = M2R_ALU;
                  end
               endcase
            end
            ST_HALT: halted = 1'b1;
            default: begin
               err_nxt   = 1'b1;
               state_nxt = ST_HALT;
            end
         endcase
      end
   end

   assign state   = state_r;
   assign err     = err_r;
   assign retired = retired_r;

endmodule
